// File: rtl/rs_entry_alloc_if.sv
// Dispatch-side bundle for the RS entry-allocation tracker: the allocation
// request, psel_gen grants, entry release, and occupancy status.
interface rs_entry_alloc_if #(
  parameter int REQS  = 4,
  parameter int WIDTH = 8
);
  localparam int IDX = $clog2(WIDTH);
  localparam int NW  = $clog2(REQS+1);
  localparam int CW  = $clog2(WIDTH+1);

  logic                  alloc_valid;
  logic [NW-1:0]         alloc_num;
  logic [WIDTH-1:0]      free_vec;
  logic                  flush;
  logic [WIDTH*REQS-1:0] psel_gnt_bus;
  logic [WIDTH-1:0]      psel_req;
  logic                  alloc_ok;
  logic [REQS*IDX-1:0]   alloc_idx;
  logic [REQS-1:0]       alloc_idx_valid;
  logic [WIDTH-1:0]      busy;
  logic [CW-1:0]         free_count;
  logic                  full;

  modport master (
    output alloc_valid, alloc_num, free_vec, flush, psel_gnt_bus,
    input  psel_req, alloc_ok, alloc_idx, alloc_idx_valid, busy, free_count, full
  );
  modport slave (
    input  alloc_valid, alloc_num, free_vec, flush, psel_gnt_bus,
    output psel_req, alloc_ok, alloc_idx, alloc_idx_valid, busy, free_count, full
  );
endinterface

// File: rtl/rs_entry_alloc.sv
// Reservation-station entry allocator: busy bits feed psel_gen, its per-slot
// one-hot grants are committed all-or-nothing, entries release on issue/flush.
module rs_slot #(
  parameter int WIDTH = 8,
  parameter int IDX   = 3
) (
  input  logic             en,
  input  logic [WIDTH-1:0] gnt,
  output logic [IDX-1:0]   idx,
  output logic             vld,
  output logic [WIDTH-1:0] mask
);
  // OR-encode is exact for a one-hot slice and yields 0 for an empty one
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (gnt[i]) idx = idx | IDX'(i);
  end

  assign vld  = en & (|gnt);
  assign mask = en ? gnt : '0;
endmodule

module rs_entry_alloc #(
  parameter int REQS  = 4,
  parameter int WIDTH = 8
) (
  input logic          clock,
  input logic          reset,
  rs_entry_alloc_if.slave bus
);
  localparam int IDX = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH+1);

  logic [WIDTH-1:0]            busy_q, busy_nxt, alloc_mask;
  logic [CW-1:0]               free_q, free_nxt;
  logic                        full_q, ok;
  logic [REQS-1:0][WIDTH-1:0]  gnt, mask;
  logic [REQS-1:0][IDX-1:0]    idx;
  logic [REQS-1:0]             en, vld;

  assign gnt = bus.psel_gnt_bus;

  assign ok = bus.alloc_valid & (int'(bus.alloc_num) <= REQS) &
              (int'(bus.alloc_num) <= int'(free_q)) & ~bus.flush;

  for (genvar k = 0; k < REQS; k++) begin : g_slot
    assign en[k] = ok & (k < int'(bus.alloc_num));
    rs_slot #(.WIDTH(WIDTH), .IDX(IDX)) u_slot (
      .en   (en[k]),
      .gnt  (gnt[k]),
      .idx  (idx[k]),
      .vld  (vld[k]),
      .mask (mask[k])
    );
  end

  always_comb begin
    alloc_mask = '0;
    for (int k = 0; k < REQS; k++) alloc_mask = alloc_mask | mask[k];
  end

  // Flush wins over same-cycle free and alloc
  assign busy_nxt = bus.flush ? '0 : ((busy_q & ~bus.free_vec) | alloc_mask);

  always_comb begin
    free_nxt = '0;
    for (int i = 0; i < WIDTH; i++)
      if (!busy_nxt[i]) free_nxt = free_nxt + CW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      free_q <= CW'(WIDTH);
      full_q <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      free_q <= free_nxt;
      full_q <= (free_nxt == '0);
    end
  end

  // psel_gen must never grant an entry that is still occupied
  a_gnt_busy: assert property (@(posedge clock) disable iff (!reset)
    (alloc_mask & busy_q) == '0);

  assign bus.psel_req        = ~busy_q;
  assign bus.alloc_ok        = ok;
  assign bus.alloc_idx       = idx;
  assign bus.alloc_idx_valid = vld;
  assign bus.busy            = busy_q;
  assign bus.free_count      = free_q;
  assign bus.full            = full_q;
endmodule

// File: tb/tb_rs_entry_alloc.sv
// Directed + random bench for rs_entry_alloc against a per-entry occupancy model.
module tb_rs_entry_alloc;
  localparam int REQS  = 4;
  localparam int WIDTH = 8;
  localparam int IDX   = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rs_entry_alloc_if #(.REQS(REQS), .WIDTH(WIDTH)) bus ();
  rs_entry_alloc #(.REQS(REQS), .WIDTH(WIDTH)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;
  bit mb[WIDTH];  // model: occupied entries

  function automatic logic [WIDTH-1:0] mvec();
    logic [WIDTH-1:0] v = '0;
    for (int i = 0; i < WIDTH; i++) v[i] = mb[i];
    return v;
  endfunction

  function automatic int mfree();
    int c = 0;
    for (int i = 0; i < WIDTH; i++) if (!mb[i]) c++;
    return c;
  endfunction

  function automatic int enc(input logic [WIDTH-1:0] s);
    for (int i = 0; i < WIDTH; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // One cycle: drive, check comb outputs, clock, update model, check registers.
  task automatic step(input bit av, input int num, input logic [WIDTH-1:0] fv,
                      input bit fl, input logic [REQS-1:0][WIDTH-1:0] g);
    bit ok;
    logic [WIDTH-1:0] ep, eb;
    logic [REQS-1:0]  ev;
    logic [3:0]       ef;
    bus.alloc_valid  = av;
    bus.alloc_num    = 3'(num);
    bus.free_vec     = fv;
    bus.flush        = fl;
    bus.psel_gnt_bus = g;
    #1;
    ok = av && (num <= REQS) && (num <= mfree()) && !fl;
    ep = ~mvec();
    check("psel_req", bus.psel_req, ep);
    check("alloc_ok", bus.alloc_ok, ok);
    for (int k = 0; k < REQS; k++) begin
      ev[k] = ok && (k < num) && (g[k] != '0);
      check($sformatf("alloc_idx%0d", k), bus.alloc_idx[k*IDX +: IDX], enc(g[k]));
    end
    check("idx_valid", bus.alloc_idx_valid, ev);
    @(posedge clock); #1;
    if (fl) begin
      for (int i = 0; i < WIDTH; i++) mb[i] = 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) if (fv[i]) mb[i] = 1'b0;
      if (ok)
        for (int k = 0; k < num; k++)
          for (int i = 0; i < WIDTH; i++) if (g[k][i]) mb[i] = 1'b1;
    end
    eb = mvec();
    ef = 4'(mfree());
    check("busy", bus.busy, eb);
    check("free_count", bus.free_count, ef);
    check("full", bus.full, ef == 0);
  endtask

  initial begin
    logic [REQS-1:0][WIDTH-1:0] g;
    logic [WIDTH-1:0] fv;
    int fl_list[$];
    int num;
    bit av, fl;

    bus.alloc_valid = 0; bus.alloc_num = 0; bus.free_vec = 0;
    bus.flush = 0; bus.psel_gnt_bus = '0;
    for (int i = 0; i < WIDTH; i++) mb[i] = 1'b0;

    // reset state
    #12;
    check("rst_busy", bus.busy, 8'h00);
    check("rst_psel_req", bus.psel_req, 8'hFF);
    check("rst_free_count", bus.free_count, 4'd8);
    check("rst_full", bus.full, 1'b0);
    reset = 1'b1;

    // alloc 3 of 4 offered grants -> busy C1
    step(1, 3, 8'h00, 0, {8'h02, 8'h40, 8'h01, 8'h80});
    check("t2_busy", bus.busy, 8'hC1);
    // free 6,0 while allocating 5,1 -> busy A2
    step(1, 2, 8'h41, 0, {8'h00, 8'h00, 8'h02, 8'h20});
    check("t4_busy", bus.busy, 8'hA2);
    // flush beats alloc
    step(1, 2, 8'h00, 1, {8'h00, 8'h00, 8'h04, 8'h01});
    check("t5_busy", bus.busy, 8'h00);
    // fill up, then a request is refused while full
    step(1, 4, 8'h00, 0, {8'h08, 8'h04, 8'h02, 8'h01});
    step(1, 4, 8'h00, 0, {8'h80, 8'h40, 8'h20, 8'h10});
    check("t3_full", bus.full, 1'b1);
    step(1, 1, 8'h00, 0, '0);
    check("t3_busy", bus.busy, 8'hFF);
    // alloc_num above REQS is rejected
    step(0, 0, 8'h00, 1, '0);
    step(1, 5, 8'h00, 0, {8'h08, 8'h04, 8'h02, 8'h01});
    check("over_busy", bus.busy, 8'h00);
    // alloc_num 0 is accepted and allocates nothing
    step(1, 0, 8'h00, 0, {8'h08, 8'h04, 8'h02, 8'h01});
    // busy 0F, then reset pulsed mid-cycle
    step(1, 4, 8'h00, 0, {8'h08, 8'h04, 8'h02, 8'h01});
    check("t6_free", bus.free_count, 4'd4);
    bus.alloc_valid = 1; bus.alloc_num = 3'd4; bus.free_vec = 0; bus.flush = 0;
    bus.psel_gnt_bus = {8'h80, 8'h40, 8'h20, 8'h10};
    #1;
    check("t6_ok", bus.alloc_ok, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("t6_rst_busy", bus.busy, 8'h00);
    check("t6_rst_free", bus.free_count, 4'd8);
    check("t6_rst_full", bus.full, 1'b0);
    bus.alloc_valid = 0; bus.psel_gnt_bus = '0;
    for (int i = 0; i < WIDTH; i++) mb[i] = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;

    // random traffic with grants drawn from the model's free entries
    for (int it = 0; it < 400; it++) begin
      fl_list.delete();
      for (int i = 0; i < WIDTH; i++) if (!mb[i]) fl_list.push_back(i);
      fl_list.shuffle();
      g = '0;
      for (int k = 0; k < REQS; k++)
        if (k < fl_list.size()) g[k][fl_list[k]] = 1'b1;
      num = $urandom_range(0, 9);
      if (num > REQS) num = $urandom_range(0, 7);
      av = ($urandom_range(0, 3) != 0);
      fv = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      fl = ($urandom_range(0, 19) == 0);
      if (num > REQS) begin fv = '0; fl = 1'b0; end
      step(av, num, fv, fl, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
